// File: rtl/clk_meter_pkg.sv
// Shared types and helpers for the clock period meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArm   = 2'd1,
    StTrack = 2'd2,
    StLock  = 2'd3
  } meter_state_e;

  // Unsigned |a - b|, one bit wider than the operands so the difference never wraps.
  function automatic logic [32:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] wa;
    logic [32:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

endpackage

// File: rtl/clk_sync_edge.sv
// Two-flop synchronizer plus one delay stage; reports level and single-cycle rise/fall.
module clk_sync_edge (
  input  logic CLK_IN,
  input  logic RST_N,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of an asynchronous clock in CLK_IN cycles, with lock and loss detection.
// Define CLK_PERIOD_METER_DUTY_EN to add the HIGH_TIME (high-phase length) output.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TOL      = 1
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             CLK_MON,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VLD,
  output logic             LOCKED,
  output logic             LOST
`ifdef CLK_PERIOD_METER_DUTY_EN
  ,
  output logic [CNT_W-1:0] HIGH_TIME
`endif
);

  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);

  logic mon_level, mon_rise, mon_fall;

  clk_sync_edge u_sync (
    .CLK_IN  (CLK_IN),
    .RST_N   (RST_N),
    .async_in(CLK_MON),
    .level   (mon_level),
    .rise    (mon_rise),
    .fall    (mon_fall)
  );

  meter_state_e      state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  ref_q;
  logic [MatchW-1:0] match_q;
  logic              is_match;
  logic              timeout;

  assign is_match = abs_diff(32'(cnt_q), 32'(ref_q)) <= 33'(TOL);
  // A rise on the timeout cycle is a valid period, so it suppresses the timeout.
  assign timeout  = (state_q != StIdle) && (cnt_q == TimeoutLast) && !mon_rise;

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (mon_rise) begin
      cnt_q <= CNT_W'(1);
    end else if (cnt_q != TimeoutVal) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      ref_q      <= '0;
      match_q    <= '0;
      PERIOD     <= '0;
      PERIOD_VLD <= 1'b0;
      LOCKED     <= 1'b0;
      LOST       <= 1'b0;
    end else begin
      PERIOD_VLD <= 1'b0;
      if (timeout) begin
        state_q <= StIdle;
        LOST    <= 1'b1;
        LOCKED  <= 1'b0;
      end else if (mon_rise) begin
        case (state_q)
          StIdle: begin
            state_q <= StArm;
            LOST    <= 1'b0;
          end
          StArm: begin
            state_q    <= StTrack;
            PERIOD     <= cnt_q;
            PERIOD_VLD <= 1'b1;
            ref_q      <= cnt_q;
            match_q    <= MatchW'(1);
          end
          StTrack, StLock: begin
            PERIOD     <= cnt_q;
            PERIOD_VLD <= 1'b1;
            if (!is_match) begin
              state_q <= StTrack;
              LOCKED  <= 1'b0;
              ref_q   <= cnt_q;
              match_q <= MatchW'(1);
            end else if (state_q == StTrack) begin
              match_q <= match_q + MatchW'(1);
              if (match_q == MatchLast) begin
                state_q <= StLock;
                LOCKED  <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef CLK_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hi_cnt_q;
  logic [CNT_W-1:0] hi_cap_q;

  // HIGH_TIME follows the same update/clear events as PERIOD and the IDLE transition.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      hi_cnt_q  <= '0;
      hi_cap_q  <= '0;
      HIGH_TIME <= '0;
    end else begin
      if (mon_rise) begin
        hi_cnt_q <= CNT_W'(1);
      end else if (mon_level && (hi_cnt_q != TimeoutVal)) begin
        hi_cnt_q <= hi_cnt_q + CNT_W'(1);
      end
      if (mon_fall) begin
        hi_cap_q <= hi_cnt_q;
      end
      if (timeout) begin
        HIGH_TIME <= '0;
      end else if (mon_rise && (state_q != StIdle)) begin
        HIGH_TIME <= hi_cap_q;
      end
    end
  end
`else
  logic unused_mon;
  assign unused_mon = ^{mon_level, mon_fall};
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized self-checking bench for clk_period_meter against a run-length reference model.
module tb_clk_period_meter;

  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 1000;
  localparam int LOCK_CNT = 4;
  localparam int TOL      = 1;

  logic             CLK_IN = 1'b0;
  logic             RST_N  = 1'b0;
  logic             CLK_MON;
  logic [CNT_W-1:0] PERIOD;
  logic             PERIOD_VLD;
  logic             LOCKED;
  logic             LOST;
  logic [CNT_W-1:0] unused_t0_period;
  logic             unused_t0_vld;
  logic             unused_t0_lost;
  logic             t0_locked;
`ifdef CLK_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] HIGH_TIME;
  logic [CNT_W-1:0] unused_t0_high;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK_IN = ~CLK_IN;

  clk_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .LOCK_CNT(LOCK_CNT),
    .TOL     (TOL)
  ) u_dut (
    .CLK_IN    (CLK_IN),
    .RST_N     (RST_N),
    .CLK_MON   (CLK_MON),
    .PERIOD    (PERIOD),
    .PERIOD_VLD(PERIOD_VLD),
    .LOCKED    (LOCKED),
    .LOST      (LOST)
`ifdef CLK_PERIOD_METER_DUTY_EN
    ,
    .HIGH_TIME (HIGH_TIME)
`endif
  );

  // Zero-tolerance instance, only watched during the alternating 10/11 stretch.
  clk_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .LOCK_CNT(LOCK_CNT),
    .TOL     (0)
  ) u_dut_t0 (
    .CLK_IN    (CLK_IN),
    .RST_N     (RST_N),
    .CLK_MON   (CLK_MON),
    .PERIOD    (unused_t0_period),
    .PERIOD_VLD(unused_t0_vld),
    .LOCKED    (t0_locked),
    .LOST      (unused_t0_lost)
`ifdef CLK_PERIOD_METER_DUTY_EN
    ,
    .HIGH_TIME (unused_t0_high)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Stimulus: queue of (high, low) phase lengths in CLK_IN cycles, changed on negedges.
  int q_hi[$];
  int q_lo[$];

  task automatic push_pairs(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      q_hi.push_back(hi);
      q_lo.push_back(lo);
    end
  endtask

  initial begin
    int h;
    int l;
    CLK_MON = 1'b0;
    forever begin
      if (q_hi.size() == 0) begin
        @(negedge CLK_IN);
      end else begin
        h = q_hi.pop_front();
        l = q_lo.pop_front();
        CLK_MON = 1'b1;
        repeat (h) @(negedge CLK_IN);
        CLK_MON = 1'b0;
        repeat (l) @(negedge CLK_IN);
      end
    end
  end

  // Reference model: periods are distances between rising edges (seen after a fixed
  // 3-cycle delay); lock means LOCK_CNT consecutive periods within TOL of the run's first.
  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  int cyc = 0;
  int last_rise = 0;
  bit h1 = 0, h2 = 0, h3 = 0;
  bit m_active = 0, m_have_ref = 0;
  int m_ref = 0, m_run = 0, m_period = 0;
  bit m_locked = 0, m_lost = 0, m_vld = 0;
  int m_hi = 0, m_hicap = 0, m_ht = 0;

  always @(posedge CLK_IN or negedge RST_N) begin
    int p;
    if (!RST_N) begin
      h1 = 0; h2 = 0; h3 = 0;
      m_active = 0; m_have_ref = 0; m_ref = 0; m_run = 0; m_period = 0;
      m_locked = 0; m_lost = 0; m_vld = 0;
      m_hi = 0; m_hicap = 0; m_ht = 0;
    end else begin
      cyc++;
      m_vld = 0;
      if (h2 && !h3) begin
        if (m_active) begin
          p = cyc - last_rise;
          m_period = p;
          m_vld = 1;
          m_ht = m_hicap;
          if (m_have_ref && absdiff(p, m_ref) <= TOL) begin
            m_run++;
            if (m_run >= LOCK_CNT) m_locked = 1;
          end else begin
            m_have_ref = 1;
            m_ref = p;
            m_run = 1;
            m_locked = 0;
          end
        end else begin
          m_active = 1;
          m_have_ref = 0;
          m_lost = 0;
        end
        last_rise = cyc;
      end else if (m_active && (cyc - last_rise == TIMEOUT - 1)) begin
        m_active = 0;
        m_lost = 1;
        m_locked = 0;
        m_ht = 0;
      end
      if (h2 && !h3) m_hi = 1;
      else if (h2) m_hi++;
      if (!h2 && h3) m_hicap = m_hi;
      h3 = h2;
      h2 = h1;
      h1 = CLK_MON;
    end
  end

  always @(negedge CLK_IN) begin
    check_eq("cyc_vld", PERIOD_VLD, m_vld);
    check_eq("cyc_locked", LOCKED, m_locked);
    check_eq("cyc_lost", LOST, m_lost);
    check_eq("cyc_period", PERIOD, m_period);
`ifdef CLK_PERIOD_METER_DUTY_EN
    check_eq("cyc_high_time", HIGH_TIME, m_ht);
`endif
  end

  task automatic wait_vld(input string tag);
    int n = 0;
    do begin
      @(negedge CLK_IN);
      n++;
    end while (!PERIOD_VLD && n < 3000);
    check_eq({tag, "_vld"}, PERIOD_VLD, 1);
  endtask

  task automatic wait_lost(input string tag);
    int n = 0;
    while (q_hi.size() != 0 && n < 20000) begin
      @(negedge CLK_IN);
      n++;
    end
    repeat (60) @(negedge CLK_IN);
    n = 0;
    while (!LOST && n < 3000) begin
      @(negedge CLK_IN);
      n++;
    end
    check_eq({tag, "_lost"}, LOST, 1);
  endtask

  initial begin
    int n;
    int base;
    int per;
    int hi;
    int cnt;

    repeat (3) @(negedge CLK_IN);
    check_eq("rst_period", PERIOD, 0);
    check_eq("rst_vld", PERIOD_VLD, 0);
    check_eq("rst_locked", LOCKED, 0);
    check_eq("rst_lost", LOST, 0);
    RST_N = 1'b1;

    // Divide-by-10 from reset, then one 13-cycle period, then back to 10.
    push_pairs(3, 7, 6);
    push_pairs(3, 10, 1);
    push_pairs(3, 7, 7);
    wait_vld("s1_v1");
    check_eq("s1_first_period", PERIOD, 10);
    check_eq("s1_unlocked_v1", LOCKED, 0);
`ifdef CLK_PERIOD_METER_DUTY_EN
    check_eq("s6_high_time", HIGH_TIME, 3);
`endif
    wait_vld("s1_v2");
    wait_vld("s1_v3");
    check_eq("s1_unlocked_v3", LOCKED, 0);
    wait_vld("s1_v4");
    check_eq("s1_locked_v4", LOCKED, 1);
    wait_vld("s1_v5");
    wait_vld("s1_v6");
    check_eq("s1_still_locked", LOCKED, 1);
    wait_vld("s2_v7");
    check_eq("s2_period13", PERIOD, 13);
    check_eq("s2_unlock", LOCKED, 0);
    wait_vld("s2_v8");
    wait_vld("s2_v9");
    wait_vld("s2_v10");
    check_eq("s2_not_yet", LOCKED, 0);
    wait_vld("s2_v11");
    check_eq("s2_relock", LOCKED, 1);
    wait_vld("s2_v12");
    wait_vld("s2_v13");

    // Clock stops: loss after TIMEOUT-1 cycles from the last accepted rise.
    n = 0;
    while (!LOST && n < 3000) begin
      @(negedge CLK_IN);
      n++;
    end
    check_eq("s3_lost_latency", n, TIMEOUT - 1);
    check_eq("s3_lost", LOST, 1);
    check_eq("s3_unlocked", LOCKED, 0);

    push_pairs(3, 7, 3);
    n = 0;
    while (LOST && n < 3000) begin
      @(negedge CLK_IN);
      n++;
    end
    check_eq("s3_lost_cleared", LOST, 0);
    check_eq("s3_no_vld_first", PERIOD_VLD, 0);
    wait_vld("s3_v1");
    check_eq("s3_restart_period", PERIOD, 10);

    // Alternating 11/10: held with TOL=1, never locked with TOL=0.
    for (int i = 0; i < 6; i++) begin
      push_pairs(3, 8, 1);
      push_pairs(3, 7, 1);
    end
    for (int i = 2; i <= 14; i++) begin
      wait_vld("s4_alt");
      if (i >= 4) check_eq("s4_alt_locked", LOCKED, 1);
      check_eq("s4_tol0_unlocked", t0_locked, 0);
    end
    wait_lost("s4");

    // Rise exactly on the timeout cycle is accepted; one cycle later is a loss.
    push_pairs(3, 7, 1);
    push_pairs(3, 996, 1);
    push_pairs(3, 7, 1);
    wait_vld("b_v1");
    wait_vld("b_v2");
    check_eq("b_period_999", PERIOD, TIMEOUT - 1);
    check_eq("b_not_lost", LOST, 0);
    wait_lost("b1");
    push_pairs(3, 7, 1);
    push_pairs(3, 997, 1);
    push_pairs(3, 7, 1);
    wait_lost("b2");

    // Random runs of jittered periods with occasional dropouts.
    for (int r = 0; r < 24; r++) begin
      base = $urandom_range(8, 40);
      cnt = $urandom_range(2, 8);
      for (int j = 0; j < cnt; j++) begin
        per = base + $urandom_range(0, 2);
        hi = $urandom_range(2, per - 2);
        push_pairs(hi, per - hi, 1);
      end
      if (r % 6 == 5) push_pairs(3, TIMEOUT + $urandom_range(0, 20), 1);
    end
    wait_lost("rnd");

    // Asynchronous reset while locked, then a fresh start.
    push_pairs(3, 7, 10);
    wait_vld("s5_v1");
    wait_vld("s5_v2");
    wait_vld("s5_v3");
    wait_vld("s5_v4");
    check_eq("s5_locked", LOCKED, 1);
    repeat (2) @(negedge CLK_IN);
    @(posedge CLK_IN);
    #3;
    RST_N = 1'b0;
    #1;
    check_eq("s5_async_period", PERIOD, 0);
    check_eq("s5_async_vld", PERIOD_VLD, 0);
    check_eq("s5_async_locked", LOCKED, 0);
    check_eq("s5_async_lost", LOST, 0);
    repeat (2) @(negedge CLK_IN);
    RST_N = 1'b1;
    wait_vld("s5_r1");
    check_eq("s5_first_period", PERIOD, 10);
    check_eq("s5_unlocked_r1", LOCKED, 0);
    wait_vld("s5_r2");
    wait_vld("s5_r3");
    wait_vld("s5_r4");
    check_eq("s5_relocked", LOCKED, 1);

    repeat (5) @(negedge CLK_IN);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
